// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit: one aligned 64-bit req/ack memory transaction per request,
// with byte-lane strobes, misalignment detection and sign/zero-extended loads.
module ysyx_22040895_lsu #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_ld_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [7:0]        mem_wmask_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_reg, state_next;
  logic              ld_reg, uns_reg, err_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg, rdata_reg;

  logic              misaligned;
  logic              in_access;
  logic [DATA_W-1:0] shifted, load_ext, store_data;
  logic [7:0]        store_mask;

  always_comb begin
    misaligned = 1'b0;
    case (req_size_i)
      2'b01:   misaligned = req_addr_i[0];
      2'b10:   misaligned = |req_addr_i[1:0];
      2'b11:   misaligned = |req_addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Extraction uses the latched request so it is stable for the whole ACCESS state.
  assign shifted = mem_rdata_i >> {addr_reg[2:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_reg)
      2'b00: load_ext = uns_reg ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      2'b01: load_ext = uns_reg ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      2'b10: load_ext = uns_reg ? {{(DATA_W-32){1'b0}}, shifted[31:0]}
                                : {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    store_data = wdata_reg;
    store_mask = 8'hFF;
    case (size_reg)
      2'b00: begin
        store_data = {8{wdata_reg[7:0]}};
        store_mask = 8'h01 << addr_reg[2:0];
      end
      2'b01: begin
        store_data = {4{wdata_reg[15:0]}};
        store_mask = 8'h03 << addr_reg[2:0];
      end
      2'b10: begin
        store_data = {2{wdata_reg[31:0]}};
        store_mask = 8'h0F << addr_reg[2:0];
      end
      default: begin
        store_data = wdata_reg;
        store_mask = 8'hFF;
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid_i) state_next = misaligned ? RESP : ACCESS;
      ACCESS:  if (mem_ack_i) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ld_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            ld_reg    <= req_ld_i;
            uns_reg   <= req_unsigned_i;
            size_reg  <= req_size_i;
            addr_reg  <= req_addr_i;
            wdata_reg <= req_wdata_i;
            err_reg   <= misaligned;
          end
          rdata_reg <= '0;
        end
        ACCESS: begin
          if (mem_ack_i) rdata_reg <= ld_reg ? load_ext : '0;
        end
        default: begin
          // Leaving RESP: response fields read zero again in IDLE.
          rdata_reg <= '0;
          err_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign in_access   = (state_reg == ACCESS);
  assign req_ready_o = (state_reg == IDLE);
  assign rsp_valid_o = (state_reg == RESP);
  assign rsp_rdata_o = rdata_reg;
  assign rsp_err_o   = err_reg;

  assign mem_req_o   = in_access;
  assign mem_we_o    = in_access & ~ld_reg;
  assign mem_addr_o  = in_access ? {addr_reg[ADDR_W-1:3], 3'b000} : '0;
  assign mem_wdata_o = (in_access & ~ld_reg) ? store_data : '0;
  assign mem_wmask_o = (in_access & ~ld_reg) ? store_mask : 8'h00;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Scoreboard bench for ysyx_22040895_lsu: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever rsp_valid_o is seen.
module tb_ysyx_22040895_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ld, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic [63:0] rsp_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    string       name;
  } exp_t;
  exp_t sbq[$];

  ysyx_22040895_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_ld_i(req_ld),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [63:0] rd, input logic err,
                      input int acc, input int lat);
    exp_t e;
    e.name = name; e.rdata = rd; e.err = err; e.acc = acc; e.lat = lat;
    sbq.push_back(e);
  endtask

  // Monitor: latency counts the acceptance cycle as cycle 0.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid_o) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d want none", cyc);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata_o, e.rdata);
        chk({e.name, "_err"}, {63'd0, rsp_err_o}, {63'd0, e.err});
        chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
        $display("rsp %s rdata=%h err=%0d latency=%0d", e.name, rsp_rdata_o,
                 rsp_err_o, cyc - e.acc);
      end
    end
  end

  task automatic issue(input logic ld, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd, input bit hold,
                       output int acc);
    bit ok = 0;
    @(negedge clk);
    req_valid = 1'b1; req_ld = ld; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    for (int k = 0; k < 20; k++) begin
      logic r;
      r = req_ready_o;
      @(posedge clk);
      if (r) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1;
    acc = cyc - 1;
    if (!hold) req_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no req_ready want accept within 20 cycles");
    end
  endtask

  task automatic respond(input string nm, input int waits, input logic [63:0] rd,
                         input logic [63:0] eaddr, input logic we,
                         input logic [7:0] mask, input logic [63:0] ewd);
    @(negedge clk);
    chk({nm, "_mem_req"}, {63'd0, mem_req_o}, 64'd1);
    chk({nm, "_ready_busy"}, {63'd0, req_ready_o}, 64'd0);
    chk({nm, "_mem_addr"}, mem_addr_o, eaddr);
    chk({nm, "_mem_we"}, {63'd0, mem_we_o}, {63'd0, we});
    chk({nm, "_mem_wmask"}, {56'd0, mem_wmask_o}, {56'd0, mask});
    chk({nm, "_mem_wdata"}, mem_wdata_o, ewd);
    if (waits > 0) begin
      repeat (waits) @(posedge clk);
      #1;
      chk({nm, "_mem_req_held"}, {63'd0, mem_req_o}, 64'd1);
      chk({nm, "_mem_addr_held"}, mem_addr_o, eaddr);
    end
    mem_ack = 1'b1;
    mem_rdata = rd;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic settle(input string nm);
    @(posedge clk);
    #1;
    chk({nm, "_idle_ready"}, {63'd0, req_ready_o}, 64'd1);
    chk({nm, "_idle_rdata"}, rsp_rdata_o, 64'd0);
  endtask

  initial begin
    int acc, acc_b;
    rst = 1'b1; req_valid = 1'b0; req_ld = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("rst_rdata", rsp_rdata_o, 64'd0);
    chk("rst_mem_addr", mem_addr_o, 64'd0);
    chk("rst_wmask", {56'd0, mem_wmask_o}, 64'd0);
    rst = 1'b0;

    issue(1'b0, 2'b11, 1'b0, 64'h8000_0010, 64'h1122334455667788, 1'b0, acc);
    push("sd", 64'd0, 1'b0, acc, 2);
    respond("sd", 0, 64'd0, 64'h8000_0010, 1'b1, 8'hFF, 64'h1122334455667788);
    settle("sd");

    issue(1'b1, 2'b00, 1'b0, 64'h8000_0005, 64'd0, 1'b0, acc);
    push("lb5", 64'd0, 1'b0, acc, 5);
    respond("lb5", 3, 64'h0080_0000_0000_0000, 64'h8000_0000, 1'b0, 8'h00, 64'd0);
    settle("lb5");

    issue(1'b1, 2'b00, 1'b0, 64'h8000_0006, 64'd0, 1'b0, acc);
    push("lb6", 64'hFFFF_FFFF_FFFF_FF80, 1'b0, acc, 5);
    respond("lb6", 3, 64'h0080_0000_0000_0000, 64'h8000_0000, 1'b0, 8'h00, 64'd0);
    settle("lb6");

    issue(1'b1, 2'b00, 1'b1, 64'h8000_0006, 64'd0, 1'b0, acc);
    push("lbu6", 64'h80, 1'b0, acc, 5);
    respond("lbu6", 3, 64'h0080_0000_0000_0000, 64'h8000_0000, 1'b0, 8'h00, 64'd0);
    settle("lbu6");

    issue(1'b0, 2'b10, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 1'b0, acc);
    push("sw", 64'd0, 1'b0, acc, 3);
    respond("sw", 1, 64'd0, 64'h8000_0000, 1'b1, 8'hF0, 64'hDEADBEEF_DEADBEEF);
    settle("sw");

    issue(1'b1, 2'b01, 1'b0, 64'h8000_0003, 64'd0, 1'b0, acc);
    push("lh_mis", 64'd0, 1'b1, acc, 1);
    @(negedge clk);
    chk("lh_mis_mem_req_resp", {63'd0, mem_req_o}, 64'd0);
    settle("lh_mis");
    chk("lh_mis_mem_req_idle", {63'd0, mem_req_o}, 64'd0);

    issue(1'b1, 2'b11, 1'b0, 64'h8000_0020, 64'd0, 1'b0, acc);
    @(negedge clk);
    chk("rstacc_mem_req", {63'd0, mem_req_o}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstacc_mem_req_drop", {63'd0, mem_req_o}, 64'd0);
    chk("rstacc_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rstacc_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 64'hAAAA_5555_AAAA_5555;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    chk("late_ack_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("late_ack_mem_req", {63'd0, mem_req_o}, 64'd0);
    repeat (3) @(posedge clk);

    issue(1'b1, 2'b11, 1'b0, 64'h8000_0008, 64'd0, 1'b1, acc);
    push("ld_a", 64'h0123_4567_89AB_CDEF, 1'b0, acc, 2);
    req_size = 2'b10;
    req_addr = 64'h8000_0004;
    respond("ld_a", 0, 64'h0123_4567_89AB_CDEF, 64'h8000_0008, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    chk("b2b_ready_resp", {63'd0, req_ready_o}, 64'd0);
    issue(1'b1, 2'b10, 1'b0, 64'h8000_0004, 64'd0, 1'b0, acc_b);
    chk("b2b_accept_gap", 64'(acc_b - acc), 64'd3);
    push("lw_b", 64'hFFFF_FFFF_89AB_CDEF, 1'b0, acc_b, 2);
    respond("lw_b", 0, 64'h89AB_CDEF_0123_4567, 64'h8000_0000, 1'b0, 8'h00, 64'd0);
    settle("lw_b");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
